imem_loader: RTL and testbench

Writer side of the instruction-memory interface. Receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Writes each word into a 32-entry instruction RAM at incrementing addresses, for use in place of the fixed-content ROM. Holds the core in reset (cpu_hold) while a load is in progress.

---
 rtl/imem_loader.sv | 149 ++++++++++++++
 tb/tb_imem_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction RAM: assembles little-endian words and writes them at incrementing addresses.
// Optional running byte checksum output enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic [ADDR_W:0]   word_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [7:0]        checksum
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  target_q, target_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        idx_q, idx_d;
    logic              byte_ready_q, byte_ready_d;
    logic              wr_en_q, wr_en_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  target_clamp;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        checksum_q, checksum_d;
`endif

    // Requests beyond the memory size are clamped so the address never wraps.
    assign target_clamp = (num_words > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_words;

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        count_d  = count_q;
        addr_d   = addr_q;
        data_d   = data_q;
        idx_d    = idx_q;
`ifdef LOADER_CHECKSUM_EN
        checksum_d = checksum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    target_d = target_clamp;
                    count_d  = '0;
                    addr_d   = '0;
                    idx_d    = '0;
`ifdef LOADER_CHECKSUM_EN
                    checksum_d = '0;
`endif
                    state_d  = (target_clamp == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (byte_valid && byte_ready_q) begin
                    data_d[{idx_q, 3'b000} +: 8] = byte_in;
                    idx_d = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    checksum_d = checksum_q + byte_in;
`endif
                    if (idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                count_d = count_q + CNT_W'(1);
                idx_d   = '0;
                if ((count_q + CNT_W'(1)) == target_q) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_COLLECT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        byte_ready_d = (state_d == S_COLLECT);
        wr_en_d      = (state_d == S_WRITE);
        cpu_hold_d   = (state_d == S_COLLECT) || (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            target_q     <= '0;
            count_q      <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            idx_q        <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            idx_q        <= idx_d;
            byte_ready_q <= byte_ready_d;
            wr_en_q      <= wr_en_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
`ifdef LOADER_CHECKSUM_EN
            checksum_q   <= checksum_d;
`endif
        end
    end

    assign byte_ready = byte_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = addr_q;
    assign wr_data    = data_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign word_count = count_q;
`ifdef LOADER_CHECKSUM_EN
    assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed-plus-random bench for imem_loader; expected writes come from a word-assembly model over the byte queue.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  num_words;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic [5:0]  word_count;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    int total = 0;
    int bad   = 0;

    logic [4:0]  obs_addr[$];
    logic [31:0] obs_data[$];

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_words  (num_words),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .word_count (word_count)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record every write strobe and check handshake/strobe exclusivity.
    always @(negedge clk) begin
        if (wr_en) begin
            obs_addr.push_back(wr_addr);
            obs_data.push_back(wr_data);
        end
        if (byte_ready || wr_en) begin
            check("ready_and_wren_exclusive", 32'(byte_ready & wr_en), 32'd0);
            check("busy_holds_cpu", 32'({cpu_hold, done}), 32'b10);
        end
    end

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_wren"},  32'(wr_en),      32'd0);
        check({tag, "_addr"},  32'(wr_addr),    32'd0);
        check({tag, "_data"},  wr_data,         32'd0);
        check({tag, "_hold"},  32'(cpu_hold),   32'd0);
        check({tag, "_done"},  32'(done),       32'd0);
        check({tag, "_wc"},    32'(word_count), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        check({tag, "_csum"},  32'(checksum),   32'd0);
`endif
    endtask

    task automatic pulse_start(input int n);
        start = 1'b1; num_words = 6'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte after a random idle gap; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int min_gap, input int max_gap);
        int gap;
        int waited;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, min_gap)) : 0;
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1; byte_in = b;
        waited = 0;
        while (!byte_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!byte_ready) check("byte_accept_timeout", 32'(waited), 32'd0);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Full load: start, stream 4*target bytes, verify against the word model.
    task automatic run_load(input string tag, input int n, input logic [7:0] bytes[$],
                            input int min_gap, input int max_gap, input int inject_at);
        int tgt;
        int c;
        int sum;
        logic [31:0] exp_word;
        tgt = (n > 32) ? 32 : n;
        obs_addr.delete(); obs_data.delete();
        pulse_start(n);
        sum = 0;
        for (int i = 0; i < 4 * tgt; i++) begin
            if (i == inject_at) pulse_start(1);
            send_byte(bytes[i], min_gap, max_gap);
            sum = (sum + int'(bytes[i])) % 256;
            if (i % 4 == 3) begin
                exp_word = 32'(bytes[i-3]) + (32'(bytes[i-2]) << 8) + (32'(bytes[i-1]) << 16) + (32'(bytes[i]) << 24);
                check({tag, "_strobe_latency"}, 32'(wr_en), 32'd1);
                check({tag, "_strobe_addr"}, 32'(wr_addr), 32'(i / 4));
                check({tag, "_strobe_data"}, wr_data, exp_word);
            end
        end
        c = 0;
        while (!done && c < 50) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_wc"}, 32'(word_count), 32'(tgt));
        check({tag, "_last_addr"}, 32'(wr_addr), 32'(tgt - 1));
        check({tag, "_nwrites"}, 32'(obs_addr.size()), 32'(tgt));
        for (int k = 0; k < tgt && k < obs_addr.size(); k++) begin
            exp_word = 32'(bytes[4*k]) + (32'(bytes[4*k+1]) << 8) + (32'(bytes[4*k+2]) << 16) + (32'(bytes[4*k+3]) << 24);
            check({tag, "_waddr"}, 32'(obs_addr[k]), 32'(k));
            check({tag, "_wdata"}, obs_data[k], exp_word);
        end
`ifdef LOADER_CHECKSUM_EN
        check({tag, "_csum"}, 32'(checksum), 32'(sum));
`endif
    endtask

    initial begin
        logic [7:0] prog[$];
        logic [7:0] rnd[$];

        reset = 1'b1; start = 1'b0; num_words = '0; byte_in = '0; byte_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("reset");

        // Basic load, back-to-back bytes.
        prog = '{8'h13, 8'h04, 8'h30, 8'h00, 8'h93, 8'h04, 8'h10, 8'h00};
        run_load("basic", 2, prog, 0, 0, -1);
        check("basic_word0_const", obs_data.size() > 0 ? obs_data[0] : 32'hx, 32'h0030_0413);
        check("basic_word1_const", obs_data.size() > 1 ? obs_data[1] : 32'hx, 32'h0010_0493);

        // Extra bytes after done are never taken.
        obs_addr.delete();
        byte_valid = 1'b1; byte_in = 8'hAA;
        repeat (4) begin
            @(negedge clk);
            check("done_no_ready", 32'(byte_ready), 32'd0);
        end
        byte_valid = 1'b0;
        check("done_no_writes", 32'(obs_addr.size()), 32'd0);

        // Zero-length load: done the next cycle, nothing written.
        pulse_start(0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_hold", 32'(cpu_hold), 32'd0);
        check("zero_wc", 32'(word_count), 32'd0);
        check("zero_addr", 32'(wr_addr), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        check("zero_csum_cleared", 32'(checksum), 32'd0);
`endif
        repeat (3) @(negedge clk);
        check("zero_no_writes", 32'(obs_addr.size()), 32'd0);

        // Same program with 1-3 idle cycles between bytes.
        run_load("gaps", 2, prog, 1, 3, -1);

        // Oversized request clamps to 32 words.
        rnd.delete();
        for (int i = 0; i < 128; i++) rnd.push_back(8'($urandom));
        run_load("clamp40", 40, rnd, 0, 1, -1);

        // Reset mid-word abandons the load.
        obs_addr.delete();
        pulse_start(3);
        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        do_reset();
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        check("midreset_no_writes", 32'(obs_addr.size()), 32'd0);

        rnd.delete();
        for (int i = 0; i < 8; i++) rnd.push_back(8'($urandom));
        run_load("after_reset", 2, rnd, 0, 2, -1);

        // Start during word 1 collection is ignored.
        rnd.delete();
        for (int i = 0; i < 12; i++) rnd.push_back(8'($urandom));
        run_load("busy_start", 3, rnd, 0, 1, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
